modsub_arbiter: RTL and testbench
=================================

// Module: modsub_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one modular subtractor (sub, clk/start/done) among NUM_REQ
//  requesters (point-arithmetic FSMs of the EdDSA core). Captures operands of the winning requester,
//  pulses sub.start, waits for sub.done, returns result to that requester. Watchdog flags a hung unit.
// PARAMETERS
//  NUM_REQ        4     number of requesters (>=2)
//  TIMEOUT_CYCLES 64    max cycles in WAIT before abort; width $clog2(TIMEOUT_CYCLES+1)
//  DATA_WIDTH     pkg   operand width, taken from parameters_pkg (448)
// PORTS
//  clk        in   1                   clock, rising edge
//  rst        in   1                   synchronous, active-high reset
//  req        in   NUM_REQ             request per requester; held high with operands until rsp_valid
//  a_flat     in   NUM_REQ*DATA_WIDTH  minuend per requester, slice i = [i*DATA_WIDTH +: DATA_WIDTH]
//  b_flat     in   NUM_REQ*DATA_WIDTH  subtrahend per requester, same slicing
//  gnt        out  NUM_REQ             one-hot grant, high from ISSUE through RESP
//  rsp_valid  out  NUM_REQ             one-hot, one-cycle pulse in RESP
//  rsp_data   out  DATA_WIDTH          (a-b) mod MODULUS, valid with rsp_valid
//  rsp_err    out  1                   high with rsp_valid when operation timed out (rsp_data = 0)
//  busy       out  1                   high whenever state != IDLE
//  sub_start  out  1                   one-cycle start pulse to sub
//  sub_a      out  DATA_WIDTH          registered operand a to sub
//  sub_b      out  DATA_WIDTH          registered operand b to sub
//  sub_result in   DATA_WIDTH          sub result
//  sub_done   in   1                   sub completion
// BEHAVIOUR
//  Reset: state=IDLE, gnt=0, rsp_valid=0, rsp_data=0, rsp_err=0, sub_start=0, sub_a=sub_b=0,
//   rr_ptr=0 (requester 0 highest priority), watchdog=0. Reset mid-operation aborts silently.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   IDLE : if |req, pick first i with req[i] scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ; register
//          sel=i, sub_a/sub_b from slice i; go ISSUE. Else stay.
//   ISSUE: gnt[sel]=1, sub_start=1 for exactly this cycle; watchdog cleared; go WAIT.
//   WAIT : sub_done ignored in ISSUE cycle, sampled from first WAIT cycle. sub_done=1 -> latch
//          rsp_data=sub_result, rsp_err=0, go RESP. Else watchdog++; at watchdog==TIMEOUT_CYCLES
//          -> rsp_data=0, rsp_err=1, go RESP.
//   RESP : rsp_valid[sel]=1 one cycle; rr_ptr=(sel+1) mod NUM_REQ; go IDLE.
//  Latency: req seen in IDLE at cycle 0 -> sub_start cycle 1 -> sub_done cycle k -> rsp_valid k+1.
//   Back-to-back: next grant earliest one cycle after RESP (IDLE re-arbitrates).
//  Operands captured in IDLE; later changes of a_flat/b_flat do not affect in-flight op.
//  req[sel] dropped mid-op: op completes, rsp_valid still pulsed, rr_ptr still advances.
//  Simultaneous requests: strictly round-robin; no requester starved beyond NUM_REQ-1 ops.
//  Only one op in flight; sub_start never asserted outside ISSUE.
//  rsp_data/rsp_err hold value until next RESP; rsp_valid is the qualifier.
// STRUCTURE
//  parameters_pkg: DATA_WIDTH, MODULUS (existing); add typedef enum logic [1:0]
//   {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arb_state_t.
//  Sub-module: rr_pick (combinational round-robin priority encoder: req, rr_ptr -> valid, idx).
//  sub is instantiated by the parent, not inside this block.
// TESTING (bench instantiates sub behind the arbiter, NUM_REQ=4)
//  1 Single req[2], a=5, b=3 -> gnt=4'b0100, sub_start 1 cycle, rsp_valid=4'b0100, rsp_data=2.
//  2 req[0], a=1, b=2 -> rsp_data=MODULUS-1, rsp_err=0.
//  3 req=4'b1111 held, all a=MODULUS-1, b=MODULUS-1 -> grants in order 0,1,2,3,0; each rsp_data=0.
//  4 Stub sub_done stuck 0 -> after 64 WAIT cycles rsp_valid pulses, rsp_err=1, rsp_data=0; busy drops.
//  5 rst pulsed in WAIT -> next cycle all outputs 0, IDLE; new req[3] then served normally.
//  6 req[1] dropped and a_flat changed after grant -> rsp_valid[1] still pulses, result from captured operands.

Source files
------------

// File: rtl/parameters_pkg.sv
// Shared field parameters for the EdDSA core (Ed448 field) and the arbiter state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package parameters_pkg;

    localparam int DATA_WIDTH = 448;

    // p = 2^448 - 2^224 - 1
    localparam logic [DATA_WIDTH-1:0] MODULUS = {
        224'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE,
        224'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF
    };

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_RESP
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority encoder: first asserted req scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on valid/idx.
//
// Ports:
//   req    [NUM_REQ-1:0]  request vector
//   rr_ptr [PTR_W-1:0]    index holding highest priority this round
//   valid                 at least one request asserted
//   idx    [PTR_W-1:0]    winning requester index (0 when !valid)
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic               valid,
    output logic [PTR_W-1:0]   idx
);

    int               sum;
    logic [PTR_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest asserted
    // requester is the last one written and therefore wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        sum   = 0;
        cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = int'(rr_ptr) + k;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            cand = PTR_W'(sum);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/modsub_arbiter.sv
// Round-robin sequencer sharing one modular subtractor among NUM_REQ requesters, with a hang watchdog.
// Latency: req seen in IDLE at cycle 0 -> sub_start cycle 1 -> sub_done cycle k -> rsp_valid cycle k+1.
// Backpressure: requesters hold req+operands until rsp_valid; one op in flight, others wait in req.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   req                  per-requester request
//   a_flat, b_flat       per-requester operands, slice i = [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt                  one-hot grant, ISSUE through RESP
//   rsp_valid            one-hot single-cycle response strobe
//   rsp_data, rsp_err    (a-b) mod p, or 0 with rsp_err on timeout; held until next response
//   busy                 arbiter not idle
//   sub_start            one-cycle start to the subtractor
//   sub_a, sub_b         captured operands to the subtractor
//   sub_result, sub_done subtractor result and completion
module modsub_arbiter
    import parameters_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   a_flat,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   b_flat,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_data,
    output logic                            rsp_err,
    output logic                            busy,
    output logic                            sub_start,
    output logic [DATA_WIDTH-1:0]           sub_a,
    output logic [DATA_WIDTH-1:0]           sub_b,
    input  logic [DATA_WIDTH-1:0]           sub_result,
    input  logic                            sub_done
);

    localparam int SEL_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t         state;
    arb_state_t         state_nxt;
    logic [SEL_W-1:0]   sel;
    logic [SEL_W-1:0]   rr_ptr;
    logic [SEL_W-1:0]   pick_idx;
    logic               pick_vld;
    logic [WD_W-1:0]    watchdog;
    logic [WD_W-1:0]    wd_inc;
    logic               wd_expire;
    logic [NUM_REQ-1:0] sel_onehot;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (SEL_W)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .valid  (pick_vld),
        .idx    (pick_idx)
    );

    // Watchdog counts WAIT cycles without sub_done; the cycle whose
    // increment reaches TIMEOUT_CYCLES is the last one spent in WAIT.
    assign wd_inc     = watchdog + WD_W'(1);
    assign wd_expire  = (wd_inc == WD_W'(TIMEOUT_CYCLES));
    assign sel_onehot = NUM_REQ'(1) << sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt       = '0;
        rsp_valid = '0;
        sub_start = 1'b0;
        busy      = (state != ARB_IDLE);
        case (state)
            ARB_IDLE: begin
                if (pick_vld) begin
                    state_nxt = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                gnt       = sel_onehot;
                sub_start = 1'b1;
                state_nxt = ARB_WAIT;
            end
            ARB_WAIT: begin
                gnt = sel_onehot;
                if (sub_done || wd_expire) begin
                    state_nxt = ARB_RESP;
                end
            end
            ARB_RESP: begin
                gnt       = sel_onehot;
                rsp_valid = sel_onehot;
                state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel      <= '0;
            rr_ptr   <= '0;
            watchdog <= '0;
            sub_a    <= '0;
            sub_b    <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    // Operands are frozen here so later changes on the
                    // request side cannot disturb the op in flight.
                    if (pick_vld) begin
                        sel   <= pick_idx;
                        sub_a <= a_flat[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
                        sub_b <= b_flat[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                ARB_ISSUE: begin
                    watchdog <= '0;
                end
                ARB_WAIT: begin
                    if (sub_done) begin
                        rsp_data <= sub_result;
                        rsp_err  <= 1'b0;
                    end else begin
                        watchdog <= wd_inc;
                        if (wd_expire) begin
                            rsp_data <= '0;
                            rsp_err  <= 1'b1;
                        end
                    end
                end
                ARB_RESP: begin
                    // Served requester drops to lowest priority next round.
                    rr_ptr <= (sel == SEL_W'(NUM_REQ - 1)) ? '0 : sel + SEL_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_modsub_arbiter.sv
// Testbench for modsub_arbiter: directed scenarios plus randomized traffic against a reference model.
// Latency: n/a.
// Backpressure: requester model holds req and operands until its rsp_valid.
module tb_modsub_arbiter;
    import parameters_pkg::*;

    localparam int N  = 4;
    localparam int TO = 64;
    localparam int DW = DATA_WIDTH;

    typedef logic [DW-1:0] word_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req;
    logic [N*DW-1:0]   a_flat;
    logic [N*DW-1:0]   b_flat;
    logic [N-1:0]      gnt;
    logic [N-1:0]      rsp_valid;
    word_t             rsp_data;
    logic              rsp_err;
    logic              busy;
    logic              sub_start;
    word_t             sub_a;
    word_t             sub_b;
    word_t             sub_result;
    logic              sub_done;

    modsub_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .a_flat     (a_flat),
        .b_flat     (b_flat),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .sub_start  (sub_start),
        .sub_a      (sub_a),
        .sub_b      (sub_b),
        .sub_result (sub_result),
        .sub_done   (sub_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cycle    = 0;

    // Subtractor model state
    word_t op_a, op_b;
    int    sub_cnt   = 0;
    int    sub_lat   = 1;
    int    lat_used  = 0;
    bit    sub_stuck = 1'b0;

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic word_t modsub_ref(input word_t a, input word_t b);
        logic [DW:0] t;
        if (a >= b) return a - b;
        t = {1'b0, a} + {1'b0, MODULUS} - {1'b0, b};
        return t[DW-1:0];
    endfunction

    function automatic word_t rand_word();
        word_t w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic word_t rand_operand();
        word_t w;
        w = rand_word();
        case ($urandom_range(0, 3))
            0:       w = word_t'($urandom_range(0, 15));
            1:       w = MODULUS - word_t'($urandom_range(1, 8));
            default: if (w >= MODULUS) w = w - MODULUS;
        endcase
        return w;
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        return N'(1) << i;
    endfunction

    task automatic set_ops(input int i, input word_t a, input word_t b);
        a_flat[i*DW +: DW] = a;
        b_flat[i*DW +: DW] = b;
    endtask

    // Advance one cycle; the subtractor model reacts to what the DUT shows
    // in the new cycle (start) and answers after sub_lat cycles.
    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
        sub_done   = 1'b0;
        sub_result = rand_word();
        if (rst) begin
            sub_cnt = 0;
        end else if (sub_start) begin
            op_a     = sub_a;
            op_b     = sub_b;
            sub_cnt  = sub_lat;
            lat_used = sub_lat;
        end else if (sub_cnt > 0) begin
            sub_cnt--;
            if (sub_cnt == 0 && !sub_stuck) begin
                sub_done   = 1'b1;
                sub_result = modsub_ref(op_a, op_b);
            end
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        check({tag, ".gnt"},       DW'(gnt),       DW'(0));
        check({tag, ".rsp_valid"}, DW'(rsp_valid), DW'(0));
        check({tag, ".rsp_data"},  rsp_data,       DW'(0));
        check({tag, ".rsp_err"},   DW'(rsp_err),   DW'(0));
        check({tag, ".busy"},      DW'(busy),      DW'(0));
        check({tag, ".sub_start"}, DW'(sub_start), DW'(0));
        check({tag, ".sub_a"},     sub_a,          DW'(0));
        check({tag, ".sub_b"},     sub_b,          DW'(0));
        rst = 1'b0;
    endtask

    task automatic single_op(input string tag, input int idx, input word_t a, input word_t b,
                             input int lat, input bit stuck, input word_t exp_data, input bit exp_err);
        int n;
        int starts;
        int exp_n;
        bit seen;
        sub_lat   = lat;
        sub_stuck = stuck;
        set_ops(idx, a, b);
        req      = '0;
        req[idx] = 1'b1;
        tick();
        check({tag, ".start"}, DW'(sub_start), DW'(1));
        check({tag, ".gnt"},   DW'(gnt),       DW'(oh(idx)));
        check({tag, ".sub_a"}, sub_a, a);
        check({tag, ".sub_b"}, sub_b, b);
        n = 0; starts = 0; seen = 1'b0;
        while (!seen && n < TO + 10) begin
            tick();
            n++;
            if (sub_start) starts++;
            if (rsp_valid != '0) seen = 1'b1;
        end
        exp_n = stuck ? TO + 1 : lat + 1;
        check({tag, ".latency"},   DW'(n),         DW'(exp_n));
        check({tag, ".rsp_valid"}, DW'(rsp_valid), DW'(oh(idx)));
        check({tag, ".rsp_data"},  rsp_data,       exp_data);
        check({tag, ".rsp_err"},   DW'(rsp_err),   DW'(exp_err));
        check({tag, ".restart"},   DW'(starts),    DW'(0));
        req[idx]  = 1'b0;
        sub_stuck = 1'b0;
        tick();
        check({tag, ".idle"}, DW'({busy, gnt, rsp_valid}), DW'(0));
    endtask

    initial begin
        word_t        a6, b6;
        int           order[5];
        int           k_start, k_rsp, last_rsp, guard;
        bit           pend[N];
        word_t        ra[N], rb[N];
        logic [N-1:0] prev_req;
        logic [N-1:0] pend_vec;
        int           ptr, win, exp_w, t_start, ops, issued, j;
        bit           inflight;

        rst        = 1'b1;
        req        = '0;
        a_flat     = '0;
        b_flat     = '0;
        sub_done   = 1'b0;
        sub_result = '0;

        do_reset("reset");

        single_op("t1", 2, word_t'(5), word_t'(3), 1, 1'b0, word_t'(2), 1'b0);
        single_op("t4_timeout", 1, rand_operand(), rand_operand(), 1, 1'b1, word_t'(0), 1'b1);
        single_op("t2", 0, word_t'(1), word_t'(2), 3, 1'b0, MODULUS - word_t'(1), 1'b0);

        // Reset while waiting on the subtractor
        sub_lat = 10;
        set_ops(1, word_t'(9), word_t'(4));
        req = 4'b0010;
        tick();
        check("t5.start", DW'(sub_start), DW'(1));
        tick();
        tick();
        check("t5.busy_wait", DW'(busy), DW'(1));
        rst = 1'b1;
        req = '0;
        tick();
        check("t5.ctl_zero", DW'({gnt, rsp_valid, busy, sub_start, rsp_err}), DW'(0));
        check("t5.rsp_data", rsp_data, DW'(0));
        check("t5.sub_a",    sub_a,    DW'(0));
        check("t5.sub_b",    sub_b,    DW'(0));
        rst = 1'b0;
        a6 = rand_operand();
        b6 = rand_operand();
        single_op("t5_after", 3, a6, b6, 2, 1'b0, modsub_ref(a6, b6), 1'b0);

        // Everyone requesting: rotation starts at 0 after requester 3 was served
        order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) set_ops(i, MODULUS - word_t'(1), MODULUS - word_t'(1));
        sub_lat = 2;
        req = 4'b1111;
        k_start = 0; k_rsp = 0; last_rsp = 0; guard = 0;
        while (k_rsp < 5 && guard < 100) begin
            tick();
            guard++;
            if (sub_start && k_start < 5) begin
                check("t3.gnt", DW'(gnt), DW'(oh(order[k_start])));
                if (k_start > 0) check("t3.gap", DW'(cycle - last_rsp), DW'(2));
                k_start++;
            end
            if (rsp_valid != '0 && k_rsp < 5) begin
                check("t3.rsp_valid", DW'(rsp_valid), DW'(oh(order[k_rsp])));
                check("t3.rsp_data",  rsp_data,       DW'(0));
                k_rsp++;
                last_rsp = cycle;
                if (k_rsp == 5) req = '0;
            end
        end
        check("t3.count", DW'(k_rsp), DW'(5));
        req = '0;
        tick();

        // Request withdrawn and operands changed after the grant
        a6 = rand_operand();
        b6 = rand_operand();
        sub_lat = 4;
        set_ops(1, a6, b6);
        req = 4'b0010;
        tick();
        check("t6.gnt", DW'(gnt), DW'(4'b0010));
        req = '0;
        set_ops(1, rand_word(), rand_word());
        guard = 0;
        while (rsp_valid == '0 && guard < 20) begin
            tick();
            guard++;
        end
        check("t6.rsp_valid", DW'(rsp_valid), DW'(4'b0010));
        check("t6.rsp_data",  rsp_data,       modsub_ref(a6, b6));
        tick();
        req = 4'b1111;
        tick();
        check("t6.ptr_adv", DW'(gnt), DW'(4'b0100));
        guard = 0;
        while (rsp_valid == '0 && guard < 20) begin
            tick();
            guard++;
        end
        req = '0;
        tick();

        // Randomized traffic
        do_reset("reset2");
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        ptr = 0; win = 0; inflight = 1'b0; t_start = 0; ops = 0; issued = 0;
        prev_req = '0;
        for (int c = 0; c < 3200; c++) begin
            sub_lat = $urandom_range(1, 6);
            tick();
            if (sub_start) begin
                exp_w = -1;
                for (int k = 0; k < N; k++) begin
                    j = (ptr + k) % N;
                    if (prev_req[j] && exp_w < 0) exp_w = j;
                end
                check("rnd.one_inflight", DW'(inflight), DW'(0));
                check("rnd.gnt", DW'(gnt), (exp_w < 0) ? DW'(0) : DW'(oh(exp_w)));
                win = (exp_w < 0) ? 0 : exp_w;
                check("rnd.sub_a", sub_a, ra[win]);
                check("rnd.sub_b", sub_b, rb[win]);
                inflight = 1'b1;
                t_start  = cycle;
            end
            if (rsp_valid != '0) begin
                check("rnd.rsp_expected", DW'(inflight),        DW'(1));
                check("rnd.rsp_valid",    DW'(rsp_valid),       DW'(oh(win)));
                check("rnd.rsp_data",     rsp_data,             modsub_ref(ra[win], rb[win]));
                check("rnd.rsp_err",      DW'(rsp_err),         DW'(0));
                check("rnd.latency",      DW'(cycle - t_start), DW'(lat_used + 1));
                pend[win] = 1'b0;
                ptr       = (win + 1) % N;
                inflight  = 1'b0;
                ops++;
            end
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    if (c < 3000 && $urandom_range(0, 2) == 0) begin
                        ra[i]   = rand_operand();
                        rb[i]   = rand_operand();
                        pend[i] = 1'b1;
                        issued++;
                        set_ops(i, ra[i], rb[i]);
                    end else begin
                        set_ops(i, rand_word(), rand_word());
                    end
                end
                req[i] = pend[i];
            end
            prev_req = req;
        end
        for (int i = 0; i < N; i++) pend_vec[i] = pend[i];
        check("rnd.drained", DW'(pend_vec), DW'(0));
        check("rnd.ops",     DW'(ops),      DW'(issued));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
